// File: rtl/morse_decoder_if.sv
// Key level in, decoded character stream out: the signal bundle of morse_decoder.
interface morse_decoder_if;
  logic       key;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_char;
  logic       out_err;
  logic       overrun;

  modport master (
    input  key, out_ready,
    output out_valid, out_char, out_err, overrun
  );

  modport slave (
    output key, out_ready,
    input  out_valid, out_char, out_err, overrun
  );
endinterface

// File: rtl/morse_decoder.sv
// Timing-based Morse decoder: classifies key presses by duration, detects
// character/word gaps and emits ASCII through a one-entry valid/ready register.
module morse_decoder #(
  parameter int unsigned CLK_PER_UNIT = 1000,
  parameter int unsigned MAX_ELEMS    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  morse_decoder_if.master bus
);
  localparam int unsigned U  = CLK_PER_UNIT;
  localparam int unsigned CW = $clog2(7 * U + 1);
  localparam int unsigned LW = $clog2(MAX_ELEMS + 2);
  localparam int unsigned PW = (MAX_ELEMS > 5) ? MAX_ELEMS : 5;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] DASH_MIN = CW'(2 * U);
  localparam logic [CW-1:0] CHAR_GAP = CW'(3 * U);
  localparam logic [CW-1:0] WORD_GAP = CW'(7 * U);
  localparam logic [LW-1:0] LEN_OVER = LW'(MAX_ELEMS + 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n, cnt_inc;
  logic [MAX_ELEMS-1:0]   pat, pat_n;
  logic [LW-1:0]          len, len_n;
  logic                   is_dash;

  logic                   emit;
  logic [7:0]             emit_char;
  logic                   emit_err;

  logic                   valid_q;
  logic [7:0]             char_q;
  logic                   err_q;
  logic                   ovr_q;

  // ITU table keyed on {len, pat}; the first element sits in the MSB of the
  // len-bit pattern. Returns {err, ascii}.
  function automatic logic [8:0] lookup(input logic [LW-1:0] n,
                                        input logic [MAX_ELEMS-1:0] p);
    logic [PW-1:0] pw;
    logic [7:0]    c;
    pw = PW'(p);
    c  = 8'h3F;
    case (int'(n))
      1: c = pw[0] ? "T" : "E";
      2: case (pw[1:0])
           2'b00:   c = "I";
           2'b01:   c = "A";
           2'b10:   c = "N";
           default: c = "M";
         endcase
      3: case (pw[2:0])
           3'b000:  c = "S";
           3'b001:  c = "U";
           3'b010:  c = "R";
           3'b011:  c = "W";
           3'b100:  c = "D";
           3'b101:  c = "K";
           3'b110:  c = "G";
           default: c = "O";
         endcase
      4: case (pw[3:0])
           4'b0000: c = "H";
           4'b0001: c = "V";
           4'b0010: c = "F";
           4'b0100: c = "L";
           4'b0110: c = "P";
           4'b0111: c = "J";
           4'b1000: c = "B";
           4'b1001: c = "X";
           4'b1010: c = "C";
           4'b1011: c = "Y";
           4'b1100: c = "Z";
           4'b1101: c = "Q";
           default: c = 8'h3F;
         endcase
      5: case (pw[4:0])
           5'b01111: c = "1";
           5'b00111: c = "2";
           5'b00011: c = "3";
           5'b00001: c = "4";
           5'b00000: c = "5";
           5'b10000: c = "6";
           5'b11000: c = "7";
           5'b11100: c = "8";
           5'b11110: c = "9";
           5'b11111: c = "0";
           default:  c = 8'h3F;
         endcase
      default: c = 8'h3F;
    endcase
    // A length beyond MAX_ELEMS is overlong even if it names a listed code.
    if (int'(n) > MAX_ELEMS) c = 8'h3F;
    return {c == 8'h3F, c};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pat   <= '0;
      len   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pat   <= pat_n;
      len   <= len_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pat_n     = pat;
    len_n     = len;
    emit      = 1'b0;
    emit_char = '0;
    emit_err  = 1'b0;
    cnt_inc   = (cnt >= WORD_GAP) ? cnt : cnt + 1'b1;
    is_dash   = (cnt >= DASH_MIN);

    unique case (state)
      IDLE: begin
        if (bus.key) begin
          state_n = MARK;
          cnt_n   = CNT_ONE;
        end
      end
      MARK: begin
        if (bus.key) begin
          cnt_n = cnt_inc;
        end else begin
          pat_n   = (pat << 1) | MAX_ELEMS'(is_dash);
          len_n   = (len == LEN_OVER) ? len : len + 1'b1;
          state_n = SPACE;
          cnt_n   = CNT_ONE;
        end
      end
      SPACE: begin
        if (bus.key) begin
          state_n = MARK;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == CHAR_GAP && len != '0) begin
            emit                 = 1'b1;
            {emit_err, emit_char} = lookup(len, pat);
            pat_n                = '0;
            len_n                = '0;
          end
          if (cnt_inc == WORD_GAP) begin
            emit      = 1'b1;
            emit_char = 8'h20;
            emit_err  = 1'b0;
            state_n   = IDLE;
            cnt_n     = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Single-entry output register: a character arriving while the held one is
  // still unaccepted is dropped and flagged, never overwriting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      char_q  <= 8'h00;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (emit) begin
      if (!valid_q || bus.out_ready) begin
        valid_q <= 1'b1;
        char_q  <= emit_char;
        err_q   <= emit_err;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_char  = char_q;
  assign bus.out_err   = err_q;
  assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder: ITU table vectors, timing corner
// sequences and randomized key streams against a string-level Morse model.
module tb_morse_decoder;
  localparam int unsigned U = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  morse_decoder_if bus();

  morse_decoder #(.CLK_PER_UNIT(U), .MAX_ELEMS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  got_ch  [$];
  logic        got_err [$];
  int unsigned got_cyc [$];

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got_ch.push_back(bus.out_char);
      got_err.push_back(bus.out_err);
      got_cyc.push_back(cyc);
    end
  end

  typedef struct packed {
    logic [2:0] nel;
    logic [5:0] el;
    logic [7:0] ch;
    logic       err;
  } vec_t;

  vec_t  vecs [16];
  string codes [36];
  string alph;

  int         segs [$];
  logic [7:0] exp_ch [$];
  logic       exp_err [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic seg(input logic lvl, input int n);
    bus.key = lvl;
    tick(n);
  endtask

  task automatic clear_got();
    got_ch.delete();
    got_err.delete();
    got_cyc.delete();
  endtask

  task automatic do_reset();
    bus.key = 1'b0;
    rst_n   = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    clear_got();
  endtask

  // Elements are sent first-element-first from bit nel-1 down to bit 0.
  task automatic send_char(input int nel, input logic [5:0] el, input int gap);
    for (int i = nel - 1; i >= 0; i--) begin
      seg(1'b1, el[i] ? 3 * U : U);
      seg(1'b0, (i == 0) ? gap : U);
    end
  endtask

  function automatic void ref_lookup(input string s, output logic [7:0] c, output logic e);
    c = 8'h3F;
    e = 1'b1;
    if (s.len() > 5) return;
    for (int i = 0; i < 36; i++) begin
      if (codes[i] == s) begin
        c = alph[i];
        e = 1'b0;
      end
    end
  endfunction

  // Decode an alternating high/low duration list from the timing rules alone.
  task automatic ref_decode();
    string      s;
    logic [7:0] c;
    logic       e;
    s = "";
    exp_ch.delete();
    exp_err.delete();
    for (int i = 0; i < segs.size(); i++) begin
      if (i % 2 == 0) begin
        if (segs[i] >= 2 * U) s = {s, "-"};
        else                  s = {s, "."};
      end else begin
        if (segs[i] >= 3 * U) begin
          ref_lookup(s, c, e);
          exp_ch.push_back(c);
          exp_err.push_back(e);
          s = "";
        end
        if (segs[i] >= 7 * U) begin
          exp_ch.push_back(8'h20);
          exp_err.push_back(1'b0);
        end
      end
    end
  endtask

  initial begin
    int unsigned t0;
    int          n;
    int          lim;
    logic        dash;

    alph  = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
    codes = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
              "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
              "..-", "...-", ".--", "-..-", "-.--", "--..",
              "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
              "---..", "----."};

    vecs[0]  = '{3'd2, 6'b000001, "A", 1'b0};
    vecs[1]  = '{3'd4, 6'b001000, "B", 1'b0};
    vecs[2]  = '{3'd3, 6'b000101, "K", 1'b0};
    vecs[3]  = '{3'd4, 6'b001101, "Q", 1'b0};
    vecs[4]  = '{3'd3, 6'b000000, "S", 1'b0};
    vecs[5]  = '{3'd4, 6'b001100, "Z", 1'b0};
    vecs[6]  = '{3'd5, 6'b001111, "1", 1'b0};
    vecs[7]  = '{3'd5, 6'b000000, "5", 1'b0};
    vecs[8]  = '{3'd5, 6'b011110, "9", 1'b0};
    vecs[9]  = '{3'd5, 6'b011000, "7", 1'b0};
    vecs[10] = '{3'd2, 6'b000011, "M", 1'b0};
    vecs[11] = '{3'd1, 6'b000000, "E", 1'b0};
    vecs[12] = '{3'd1, 6'b000001, "T", 1'b0};
    vecs[13] = '{3'd4, 6'b000101, 8'h3F, 1'b1};
    vecs[14] = '{3'd4, 6'b001110, 8'h3F, 1'b1};
    vecs[15] = '{3'd6, 6'b111111, 8'h3F, 1'b1};

    bus.key       = 1'b0;
    bus.out_ready = 1'b1;
    tick(3);
    chk("reset_valid",   32'(bus.out_valid), 32'd0);
    chk("reset_char",    32'(bus.out_char),  32'h00);
    chk("reset_err",     32'(bus.out_err),   32'd0);
    chk("reset_overrun", 32'(bus.overrun),   32'd0);
    rst_n = 1'b1;
    tick(1);

    // E then word space, cycle-exact
    do_reset();
    seg(1'b1, 4);
    bus.key = 1'b0;
    t0 = cyc;
    tick(28);
    tick(2);
    chk("e_space_count", 32'(got_ch.size()), 32'd2);
    if (got_ch.size() == 2) begin
      chk("e_char",       32'(got_ch[0]),  32'h45);
      chk("e_cycle",      got_cyc[0],      t0 + 12);
      chk("space_char",   32'(got_ch[1]),  32'h20);
      chk("space_cycle",  got_cyc[1],      t0 + 28);
    end

    // A with a short intra gap
    do_reset();
    seg(1'b1, 4); seg(1'b0, 4); seg(1'b1, 12); seg(1'b0, 12);
    tick(2);
    chk("a_count", 32'(got_ch.size()), 32'd1);
    if (got_ch.size() == 1) chk("a_char", 32'(got_ch[0]), 32'h41);

    // press-length and gap boundaries
    do_reset();
    seg(1'b1, 7);  seg(1'b0, 12);
    seg(1'b1, 8);  seg(1'b0, 12);
    seg(1'b1, 4);  seg(1'b0, 11); seg(1'b1, 4); seg(1'b0, 12);
    tick(2);
    chk("bound_count", 32'(got_ch.size()), 32'd3);
    if (got_ch.size() == 3) begin
      chk("press7_dot",  32'(got_ch[0]), 32'h45);
      chk("press8_dash", 32'(got_ch[1]), 32'h54);
      chk("gap11_intra", 32'(got_ch[2]), 32'h49);
    end

    // table of lookup vectors, back to back with 3U gaps, then a word space
    do_reset();
    for (int i = 0; i < 16; i++) send_char(int'(vecs[i].nel), vecs[i].el, 3 * U);
    seg(1'b0, 20);
    tick(2);
    chk("table_count", 32'(got_ch.size()), 32'd17);
    if (got_ch.size() == 17) begin
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("table_char_%0d", i), 32'(got_ch[i]),  32'(vecs[i].ch));
        chk($sformatf("table_err_%0d", i),  32'(got_err[i]), 32'(vecs[i].err));
      end
      chk("table_space", 32'(got_ch[16]), 32'h20);
    end

    // held output with out_ready low, second character overruns
    do_reset();
    bus.out_ready = 1'b0;
    send_char(1, 6'b000000, 12);
    send_char(1, 6'b000001, 12);
    tick(1);
    chk("hold_valid",   32'(bus.out_valid), 32'd1);
    chk("hold_char",    32'(bus.out_char),  32'h45);
    chk("hold_err",     32'(bus.out_err),   32'd0);
    chk("hold_overrun", 32'(bus.overrun),   32'd1);
    chk("hold_no_accept", 32'(got_ch.size()), 32'd0);
    bus.out_ready = 1'b1;
    tick(1);
    chk("accept_count", 32'(got_ch.size()), 32'd1);
    chk("accept_valid_low", 32'(bus.out_valid), 32'd0);
    if (got_ch.size() == 1) chk("accept_char", 32'(got_ch[0]), 32'h45);

    // asynchronous reset mid-gap with a held character
    do_reset();
    bus.out_ready = 1'b0;
    send_char(1, 6'b000000, 12);
    seg(1'b1, 4); seg(1'b0, 4); seg(1'b1, 12); seg(1'b0, 5);
    rst_n = 1'b0;
    #1;
    chk("arst_valid",   32'(bus.out_valid), 32'd0);
    chk("arst_char",    32'(bus.out_char),  32'h00);
    chk("arst_err",     32'(bus.out_err),   32'd0);
    chk("arst_overrun", 32'(bus.overrun),   32'd0);
    tick(2);
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    tick(1);
    clear_got();
    send_char(1, 6'b000001, 12);
    tick(2);
    chk("post_rst_count", 32'(got_ch.size()), 32'd1);
    if (got_ch.size() == 1) chk("post_rst_char", 32'(got_ch[0]), 32'h54);

    // randomized key streams against the string-level model
    do_reset();
    segs.delete();
    for (int c = 0; c < 40; c++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        dash = 1'(($urandom_range(0, 1)));
        if (dash) segs.push_back($urandom_range(2 * U, 9 * U));
        else      segs.push_back($urandom_range(1, 2 * U - 1));
        if (i < n - 1) segs.push_back($urandom_range(1, 3 * U - 1));
      end
      if ($urandom_range(0, 3) == 0) segs.push_back($urandom_range(7 * U, 9 * U));
      else                           segs.push_back($urandom_range(3 * U, 7 * U - 1));
    end
    segs[segs.size() - 1] = 8 * U;
    ref_decode();
    for (int i = 0; i < segs.size(); i++) seg((i % 2) == 0, segs[i]);
    tick(2);
    chk("rand_count", 32'(got_ch.size()), 32'(exp_ch.size()));
    lim = (got_ch.size() < exp_ch.size()) ? got_ch.size() : exp_ch.size();
    for (int i = 0; i < lim; i++) begin
      chk($sformatf("rand_char_%0d", i), 32'(got_ch[i]),  32'(exp_ch[i]));
      chk($sformatf("rand_err_%0d", i),  32'(got_err[i]), 32'(exp_err[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/morse_decoder.md
# morse_decoder

Timing-based Morse decoder, the parametrised successor to the hand-fed dot/dash state machine. It takes a raw, already-synchronised key level and classifies each press as a dot or a dash from its duration in clock cycles. It detects character and word gaps and translates the accumulated element pattern into ASCII for A–Z and 0–9. Decoded characters leave through a single-entry valid/ready output register that feeds the display/UART path.

## Interface
- CLK_PER_UNIT, default 1000: clock cycles per Morse time unit U; legal range ≥2.
- MAX_ELEMS, default 5: longest legal code; a longer sequence decodes as an error.
- Clock  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  one clock; reset is asynchronous and active-low. Reset=0 clears all state immediately; release is synchronous to Clock.
- key  in  1  key level, 1 = key down; already synchronous to Clock.
- out_ready  in  1  consumer accepts out_char when out_valid=1.
- out_valid  out  1  out_char/out_err hold a decoded character.
- out_char  out  8  ASCII code: 0x41–0x5A, 0x30–0x39, 0x20 (word space), or 0x3F ('?').
- out_err  out  1  qualifies out_char=0x3F: the pattern was unknown or too long.
- overrun  out  1  sticky; a character was dropped because the output register was full.

## Operation
- Duration counter cnt counts consecutive samples at the current key level.
  - Saturates at 7·U.
  - Width is $clog2(7·CLK_PER_UNIT+1).
- Element accumulator holds pat[MAX_ELEMS-1:0] and len (0..MAX_ELEMS+1, saturating).
  - Dot = 0, dash = 1.
  - The newest element shifts in at the LSB.
- FSM states: IDLE, MARK, SPACE.
- IDLE (key up, nothing pending):
  - key=1 → MARK, cnt=1.
- MARK:
  - key=1 → cnt++ (saturating).
  - key=0 → classify the press: cnt<2U is a dot, otherwise a dash.
  - Append the element and increment len. If len was already MAX_ELEMS, len becomes MAX_ELEMS+1 (overlong).
  - Then → SPACE with cnt=1.
- SPACE:
  - key=1 → MARK with cnt=1. Accumulated elements are kept, so the press continues the same character.
  - key=0 → cnt++.
  - When cnt becomes 3U with len≠0: emit the lookup result, then clear pat and len.
  - When cnt becomes 7U: emit 0x20, then → IDLE.
  - A key press between 3U and 7U starts a new character and no space is emitted.
- Lookup is keyed on {len, pat} and follows the ITU table.
  - Example: A = len2 pat 01; 0 = len5 pat 11111.
  - Any unlisted pattern, or len=MAX_ELEMS+1, emits 0x3F with out_err=1.
- Output register:
  - Loads on emit when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
  - If an emit happens while out_valid=1 and out_ready=0, the new character is dropped, overrun is set, and the held character stays unchanged.
  - out_valid drops after the accept cycle unless a new character loads in that same cycle.

## Timing
- Reset values:
  - state=IDLE, cnt=0, len=0, pat=0.
  - out_valid=0, out_char=0x00, out_err=0, overrun=0.
- Reset asserted mid-character or mid-gap discards everything, including a held output character.
- Dot/dash boundary: a press of 2U−1 samples is a dot; a press of exactly 2U samples is a dash.
- Character gap:
  - The intra-character limit is 3U−1 low samples.
  - Emit happens on the edge that takes the 3U-th low sample; out_valid is high from that edge.
- Word space: out_valid rises on the edge that takes the 7U-th low sample.
- Presses longer than 7U stay a dash; the counter saturates and does not wrap.
- Throughput: at most one character per 3U cycles. The output register has no skid beyond one entry.
- out_char and out_err are stable while out_valid=1 and out_ready=0.

## Test plan
All scenarios use CLK_PER_UNIT=4 and out_ready=1 unless stated.
- Key high 4, low 28 → out_char=0x45 at the 12th low sample, then 0x20 at the 28th; exactly two out_valid pulses.
- Key high 4, low 4, high 12, low 12 → single 0x41 ('A'); no emit during the 4-cycle gap.
- Press-length boundary: a 7-cycle press then low 12 → 0x45. An 8-cycle press then low 12 → 0x54. An 11-cycle intra gap between two dots → 0x49 ('I').
- Five dashes → 0x30 with out_err=0. Six dots → 0x3F with out_err=1. Pattern ..-- (len4 0011) → 0x3F with out_err=1.
- Hold out_ready=0, then send E and T → out_char stays 0x45, overrun=1. Raise out_ready → one accept, then out_valid=0.
- Pull Reset low after ".-" with the gap in progress → all outputs at reset values. Release, then send "-" with gap 12 → only 0x54 emitted.
